// File: rtl/wait_state_gen.sv
// -----------------------------------------------------------------------------
// wait_state_gen
//
// Produces MRDY, the E-high stretch request for the EX/QX clock generator.
// Each bus cycle is classified from the decoder chip selects. The selected
// region's 4-bit wait count comes from three write-only wait registers. An
// optional external-bus wait (EXT_nWAIT) can lengthen EXT/EXTIO cycles further,
// limited by TIMEOUT.
//
// Ports
//   CLKX4         in   4x E master clock
//   nRESET        in   asynchronous active-low reset
//   QX, EX        in   clock generator phase, sequence 00 -> 10 -> 11 -> 01
//   ADDR[15:0]    in   CPU logical address (register decode only)
//   RnW           in   CPU read/not-write
//   DATA[7:0]     in   CPU data bus, sampled on register writes
//   nCSROM0..UART in   active-low chip selects from the decoder
//   EXT_nWAIT     in   asynchronous external wait request, active low
//   MRDY          out  1: E may fall, 0: hold E high
//   TIMEOUT_FLAG  out  sticky, set when an external wait reached TIMEOUT
//
// Register map (write-only, written in the 01 phase with MRDY = 1):
//   WS_REG_BASE+0 : {ROM1, ROM0}
//   WS_REG_BASE+1 : {EXT,  RAM }
//   WS_REG_BASE+2 : {UART, EXTIO}
//   WS_REG_BASE+3 : any write clears TIMEOUT_FLAG
// -----------------------------------------------------------------------------
module wait_state_gen #(
    parameter logic [15:0] WS_REG_BASE = 16'hFE14,
    parameter logic [7:0]  RST_WS0     = 8'h00,
    parameter logic [7:0]  RST_WS1     = 8'h00,
    parameter logic [7:0]  RST_WS2     = 8'h11,
    parameter logic [7:0]  TIMEOUT     = 8'd255
) (
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        QX,
    input  logic        EX,
    input  logic [15:0] ADDR,
    input  logic        RnW,
    input  logic [7:0]  DATA,
    input  logic        nCSROM0,
    input  logic        nCSROM1,
    input  logic        nCSRAM,
    input  logic        nCSEXT,
    input  logic        nCSEXTIO,
    input  logic        nCSUART,
    input  logic        EXT_nWAIT,
    output logic        MRDY,
    output logic        TIMEOUT_FLAG
);

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_10 = 2'b10,
        PH_11 = 2'b11
    } phase_e;

    // Last tmo value before the limit; the flag is set on the edge that
    // moves tmo onto TIMEOUT.
    localparam logic [7:0] TMO_LAST = TIMEOUT - 8'd1;

    phase_e      phase;
    logic        ph_load;    // 11 edge: start of the stretchable window
    logic        ph_hold;    // 01 edge: generator samples MRDY here

    logic [7:0]  ws0_q, ws0_d;
    logic [7:0]  ws1_q, ws1_d;
    logic [7:0]  ws2_q, ws2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        ext_sel_q, ext_sel_d;
    logic        flag_q, flag_d;
    logic        sync1_q, xw_q;

    logic [3:0]  nibble;
    logic        ext_honour;
    logic [15:0] reg_off;
    logic        wr_commit;

    assign phase   = phase_e'({QX, EX});
    assign ph_load = (phase == PH_11);
    assign ph_hold = (phase == PH_01);

    // Region priority: UART, EXTIO, EXT, RAM, ROM1, ROM0; no select means 0.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        nibble = 4'h0;
        if (!nCSUART)       nibble = ws2_q[7:4];
        else if (!nCSEXTIO) nibble = ws2_q[3:0];
        else if (!nCSEXT)   nibble = ws1_q[7:4];
        else if (!nCSRAM)   nibble = ws1_q[3:0];
        else if (!nCSROM1)  nibble = ws0_q[7:4];
        else if (!nCSROM0)  nibble = ws0_q[3:0];
    end

    // The external-bus qualifier is captured at the 11 edge together with the
    // wait count, so MRDY is built from flops only and never from the buses.
    assign ext_honour = ext_sel_q & ~xw_q & (tmo_q < TIMEOUT);
    assign MRDY       = (cnt_q == 8'd0) & ~ext_honour;

    assign reg_off   = ADDR - WS_REG_BASE;
    assign wr_commit = ph_hold & MRDY & ~RnW;

    always_comb begin
        ws0_d     = ws0_q;
        ws1_d     = ws1_q;
        ws2_d     = ws2_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        ext_sel_d = ext_sel_q;
        flag_d    = flag_q;

        if (ph_load) begin
            cnt_d     = {4'h0, nibble};
            tmo_d     = 8'd0;
            ext_sel_d = ~nCSEXT | ~nCSEXTIO;
        end else if (ph_hold) begin
            if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            if (ext_honour)    tmo_d = tmo_q + 8'd1;
        end

        if (wr_commit) begin
            case (reg_off)
                16'd0:   ws0_d  = DATA;
                16'd1:   ws1_d  = DATA;
                16'd2:   ws2_d  = DATA;
                16'd3:   flag_d = 1'b0;
                default: ;
            endcase
        end

        // Applied after the clear so a coincident set wins.
        if (ph_hold && ext_honour && (tmo_q == TMO_LAST)) flag_d = 1'b1;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            ws0_q     <= RST_WS0;
            ws1_q     <= RST_WS1;
            ws2_q     <= RST_WS2;
            cnt_q     <= 8'd0;
            tmo_q     <= 8'd0;
            ext_sel_q <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            ws0_q     <= ws0_d;
            ws1_q     <= ws1_d;
            ws2_q     <= ws2_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            ext_sel_q <= ext_sel_d;
            flag_q    <= flag_d;
        end
    end

    // Two-flop synchroniser for the asynchronous wait input. Both stages
    // reset to the idle (no-wait) level.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            sync1_q <= 1'b1;
            xw_q    <= 1'b1;
        end else begin
            sync1_q <= EXT_nWAIT;
            xw_q    <= sync1_q;
        end
    end

    assign TIMEOUT_FLAG = flag_q;

endmodule
